mem_model_lat: RTL and testbench

- Clocked, parametrised backing-memory model for the I-cache refill path; successor to the unclocked, fixed-line mem_sim.
- Serves one cache-line read per request over a req/ready handshake.
- Latency is configurable as fixed or pseudo-random and bounded. Out-of-range addresses are flagged.
- Returned data is a deterministic function of the address, so cache refills are self-checking.

---
 rtl/mem_model_lat_pkg.sv | 27 ++
 rtl/mem_model_lat_if.sv | 30 +++
 rtl/mem_model_lat_lfsr16.sv | 33 +++
 rtl/mem_model_lat.sv | 131 +++++++++++++
 tb/tb_mem_model_lat.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_model_lat_pkg.sv
// ============================================================================
// Module   : mem_model_pkg
// Brief    : Shared types, constants and address helper for mem_model_lat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_model_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Clears the byte-offset bits so the address points at the start of its line.
    function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_model_lat_if.sv
// ============================================================================
// Module   : mem_model_lat_if
// Brief    : Line-read request/response bus between the I-cache and the model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_model_lat_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
);
    logic                    mem_req;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_ready;
    logic [8*LINE_BYTES-1:0] mem_data;
    logic                    mem_err;
    logic                    mem_busy;

    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_data, mem_err, mem_busy
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_data, mem_err, mem_busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_model_lat_lfsr16.sv
// ============================================================================
// Module   : mem_lfsr16
// Brief    : 16-bit Galois LFSR, advancing one step per enabled clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lfsr16
    import mem_model_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_adv,
    output logic [15:0]      o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_adv) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/mem_model_lat.sv
// ============================================================================
// Module   : mem_model_lat
// Brief    : Clocked line-read memory model with fixed or bounded-random latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_model_lat
    import mem_model_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          LINE_BYTES  = 16,
    parameter int          DEPTH_LINES = 4096,
    parameter int          LAT_MODE    = 0,
    parameter int          LAT_MIN     = 4,
    parameter int          LAT_MAX     = 11,
    parameter logic [31:0] DATA_SEED   = 32'h0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input wire logic         clk,
    input wire logic         rst,
    mem_model_lat_if.slave   bus
);

    localparam int          c_WORDS    = LINE_BYTES / 4;
    localparam int          c_DATA_W   = 8 * LINE_BYTES;
    localparam int          c_LAT_TOP  = (LAT_MAX > LAT_MIN) ? LAT_MAX : LAT_MIN;
    localparam int          c_CNT_W    = $clog2(c_LAT_TOP + 1);
    localparam logic [63:0] c_LIMIT    = 64'(DEPTH_LINES) * 64'(LINE_BYTES);
    localparam logic [15:0] c_LAT_MASK = (LAT_MODE == 1) ? 16'(LAT_MAX - LAT_MIN) : 16'h0000;

    state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]     r_aligned, w_aligned_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [c_DATA_W-1:0]   r_data, w_data_nxt;
    logic [c_DATA_W-1:0]   w_line;
    logic [15:0]           w_lfsr;
    logic [c_CNT_W-1:0]    w_lat;
    logic                  w_adv;
    logic                  w_oor;

    mem_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (w_adv),
        .o_lfsr (w_lfsr)
    );

    // The mask width is LAT_MAX-LAT_MIN (2^k-1), so the sum never exceeds LAT_MAX.
    assign w_lat = (LAT_MODE == 1) ? c_CNT_W'(LAT_MIN) + c_CNT_W'(w_lfsr & c_LAT_MASK)
                                   : c_CNT_W'(LAT_MIN);

    assign w_oor = (64'(r_aligned) >= c_LIMIT);

    for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_word
        assign w_line[gi*WORD_W +: WORD_W] = (32'(r_aligned) + 32'(4 * gi)) ^ DATA_SEED;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_aligned_nxt = r_aligned;
        w_ready_nxt   = 1'b0;
        w_err_nxt     = r_err;
        w_busy_nxt    = r_busy;
        w_data_nxt    = r_data;
        w_adv         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_adv         = 1'b1;
                    w_aligned_nxt = ADDR_W'(align_addr(64'(bus.mem_addr), LINE_BYTES));
                    w_cnt_nxt     = w_lat - c_CNT_W'(1);
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = w_oor;
                    w_data_nxt  = w_oor ? '0 : w_line;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            RESP: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_aligned <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_aligned <= w_aligned_nxt;
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_err   = r_err;
    assign bus.mem_busy  = r_busy;
    assign bus.mem_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_model_lat.sv
// ============================================================================
// Module   : tb_mem_model_lat
// Brief    : Directed scoreboard bench for mem_model_lat (fixed, random, seeded).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_model_lat;
    import mem_model_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_model_lat_if #(.ADDR_W(32), .LINE_BYTES(16)) if0 ();
    mem_model_lat_if #(.ADDR_W(32), .LINE_BYTES(16)) if1 ();
    mem_model_lat_if #(.ADDR_W(32), .LINE_BYTES(16)) if2 ();

    mem_model_lat dut0 (.clk(clk), .rst(rst), .bus(if0));
    mem_model_lat #(.LAT_MODE(1), .LAT_MIN(4), .LAT_MAX(11))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    mem_model_lat #(.DATA_SEED(32'hDEAD_BEEF))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [127:0]  last_data;
    int            lat_a[1000];
    int            lat_b[1000];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] seed);
        exp_t        e;
        logic [31:0] al;
        al     = addr & ~32'hF;
        e.err  = (al >= 32'h0001_0000);
        e.data = '0;
        if (!e.err)
            for (int i = 0; i < 4; i++) e.data[i*32 +: 32] = (al + 32'(4*i)) ^ seed;
        return e;
    endfunction

    // Waits for a dut0 ready (edges counted from the accept edge), then pops the scoreboard.
    task automatic wait_ready0(input string tag);
        int   k;
        bit   got;
        exp_t e;
        k = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            k = i;
            if (if0.mem_ready) got = 1;
        end
        if (!got) begin
            check({tag, "_timeout"}, 128'(0), 128'(1));
        end else begin
            check({tag, "_lat"},  128'(k), 128'(4));
            check({tag, "_busy"}, 128'(if0.mem_busy), 128'(1));
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 128'(0), 128'(1));
            end else begin
                e = sb.pop_front();
                check({tag, "_data"}, if0.mem_data, e.data);
                check({tag, "_err"},  128'(if0.mem_err), 128'(e.err));
            end
            last_data = if0.mem_data;
        end
    endtask

    task automatic req0(input logic [31:0] addr, input logic [31:0] addr_mid,
                        input bit hold, input string tag);
        @(negedge clk);
        if0.mem_req  = 1'b1;
        if0.mem_addr = addr;
        sb.push_back(model(addr, 32'h0));
        @(posedge clk); #1;
        check({tag, "_busy_acc"}, 128'(if0.mem_busy), 128'(1));
        if0.mem_addr = addr_mid;
        wait_ready0(tag);
        if (!hold) if0.mem_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, 128'(if0.mem_ready), 128'(0));
        check({tag, "_busy_drop"},  128'(if0.mem_busy),  128'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Back-to-back requests with req held high; latency compared against an LFSR model.
    task automatic var_run(input bit second);
        logic [15:0] lf;
        logic [7:0]  seen;
        int          cnt, lat, exp_lat;
        bit          got;
        lf   = 16'hACE1;
        seen = '0;
        @(negedge clk);
        if1.mem_req  = 1'b1;
        if1.mem_addr = 32'h0;
        for (int n = 0; n < 1000; n++) begin
            cnt = 0; got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(posedge clk); #1;
                if (if1.mem_busy)  cnt++;
                if (if1.mem_ready) got = 1;
            end
            lat     = got ? cnt - 1 : -1;
            exp_lat = 4 + int'(lf & 16'h0007);
            lf      = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            check("var_lat", 128'(lat), 128'(exp_lat));
            check("var_range", 128'(lat >= 4 && lat <= 11), 128'(1));
            if (lat >= 4 && lat <= 11) seen[lat-4] = 1'b1;
            if (second) lat_b[n] = lat; else lat_a[n] = lat;
            if1.mem_addr = 32'(n + 1) << 4;
        end
        if1.mem_req = 1'b0;
        check("var_all_seen", 128'(seen), 128'(8'hFF));
        @(posedge clk); @(posedge clk);
    endtask

    initial begin
        int  diffs;
        bit  seen_ready;
        bit  got;
        if0.mem_req = 1'b0; if0.mem_addr = '0;
        if1.mem_req = 1'b0; if1.mem_addr = '0;
        if2.mem_req = 1'b0; if2.mem_addr = '0;
        last_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_ready", 128'(if0.mem_ready), 128'(0));
        check("rst_err",   128'(if0.mem_err),   128'(0));
        check("rst_busy",  128'(if0.mem_busy),  128'(0));
        check("rst_data",  if0.mem_data,        128'(0));

        req0(32'h0000_1234, 32'h0000_1234, 1'b0, "basic");
        check("basic_literal", last_data, 128'h0000123C_00001238_00001234_00001230);

        req0(32'h0001_0000, 32'h0001_0000, 1'b0, "oor");
        req0(32'h0000_0010, 32'h0000_0010, 1'b0, "after_oor");
        check("after_oor_w0", 128'(last_data[31:0]), 128'(32'h10));

        req0(32'h0000_0100, 32'h0000_0200, 1'b0, "midaddr");
        check("midaddr_w0", 128'(last_data[31:0]), 128'(32'h100));

        // Request held through RESP: one ready, then a fresh accept from IDLE.
        req0(32'h0000_0300, 32'h0000_0300, 1'b1, "hold");
        sb.push_back(model(32'h0000_0300, 32'h0));
        @(posedge clk); #1;
        check("hold_reaccept_busy", 128'(if0.mem_busy), 128'(1));
        wait_ready0("hold2");
        if0.mem_req = 1'b0;
        @(posedge clk); #1;
        check("hold2_ready_drop", 128'(if0.mem_ready), 128'(0));

        // Reset two edges into WAIT abandons the request.
        @(negedge clk); if0.mem_req = 1'b1; if0.mem_addr = 32'h40;
        @(posedge clk); #1;
        check("midrst_busy_acc", 128'(if0.mem_busy), 128'(1));
        @(negedge clk); if0.mem_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (if0.mem_ready) seen_ready = 1;
        end
        check("midrst_no_ready", 128'(seen_ready), 128'(0));
        check("midrst_busy",     128'(if0.mem_busy), 128'(0));
        check("midrst_err",      128'(if0.mem_err),  128'(0));
        check("midrst_data",     if0.mem_data,       128'(0));
        req0(32'h0000_0010, 32'h0000_0010, 1'b0, "post_rst");

        pulse_reset();
        var_run(1'b0);
        pulse_reset();
        var_run(1'b1);
        diffs = 0;
        for (int n = 0; n < 1000; n++) if (lat_a[n] != lat_b[n]) diffs++;
        check("var_rerun_diffs", 128'(diffs), 128'(0));

        @(negedge clk); if2.mem_req = 1'b1; if2.mem_addr = 32'h0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (if2.mem_req && if2.mem_busy) if2.mem_req = 1'b0;
            if (if2.mem_ready) got = 1;
        end
        check("seed_ready", 128'(got), 128'(1));
        check("seed_w0",   128'(if2.mem_data[31:0]),  128'(32'hDEAD_BEEF));
        check("seed_w1",   128'(if2.mem_data[63:32]), 128'(32'hDEAD_BEEB));
        check("seed_line", if2.mem_data, model(32'h0, 32'hDEAD_BEEF).data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
